// File: rtl/uart_mmio_sequencer.sv
// Drives the UART IP register port in place of the CPU: buffers TX bytes, runs the
// load/start/release/finish handshake per byte, and drains received bytes to a consumer.
module uart_mmio_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int START_WAIT = 16,
    parameter int TX_TIMEOUT = 200000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            tx_byte,
    input  logic                  tx_push,
    output logic                  tx_full,
    output logic                  tx_empty,
    output logic [7:0]            rx_byte,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_timeout,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] uart_address,
    output logic [DATA_WIDTH-1:0] uart_wd,
    output logic                  uart_we,
    input  logic [DATA_WIDTH-1:0] uart_rd
);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int PW        = AW + 1;
    localparam int CNT_MAX_V = (START_WAIT > TX_TIMEOUT) ? START_WAIT : TX_TIMEOUT;
    localparam int CW        = $clog2(CNT_MAX_V + 1);

    localparam logic [CW-1:0] START_LIM   = CW'(START_WAIT);
    localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TX_TIMEOUT);

    localparam logic [DATA_WIDTH-1:0] REG_TX_DATA   = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] REG_TX_START  = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] REG_TX_FINISH = DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] REG_RX_DATA   = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] REG_RX_FLAG   = DATA_WIDTH'(5);
    localparam logic [DATA_WIDTH-1:0] REG_RX_CLR    = DATA_WIDTH'(6);
    localparam logic [DATA_WIDTH-1:0] WD_ONE        = DATA_WIDTH'(1);

    typedef enum logic [3:0] {
        IDLE, RX_READ, RX_CLR1, RX_CLR0, TX_LOAD, TX_GO, TX_REL, TX_WLOW, TX_WHIGH
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [7:0]      fifo_head;
    logic            push_ok;
    logic            pop;
    logic            unused_rd;

    assign unused_rd = ^uart_rd[DATA_WIDTH-1:8];

    assign tx_empty  = (wr_ptr == rd_ptr);
    assign tx_full   = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok   = tx_push && !tx_full;
    assign pop       = (state == TX_LOAD);
    assign fifo_head = fifo_mem[rd_ptr[AW-1:0]];
    assign busy      = (state != IDLE);

    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= tx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Each branch loads the bus outputs for the state being entered, so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            uart_address <= REG_RX_FLAG;
            uart_wd      <= '0;
            uart_we      <= 1'b0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            tx_timeout   <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            uart_we  <= 1'b0;
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (uart_rd[0]) begin
                        state        <= RX_READ;
                        uart_address <= REG_RX_DATA;
                    end else if (!tx_empty) begin
                        state        <= TX_LOAD;
                        uart_address <= REG_TX_DATA;
                        uart_wd      <= {{(DATA_WIDTH-8){1'b0}}, fifo_head};
                        uart_we      <= 1'b1;
                    end
                end
                RX_READ: begin
                    rx_byte      <= uart_rd[7:0];
                    rx_valid     <= 1'b1;
                    state        <= RX_CLR1;
                    uart_address <= REG_RX_CLR;
                    uart_wd      <= WD_ONE;
                    uart_we      <= 1'b1;
                end
                RX_CLR1: begin
                    state        <= RX_CLR0;
                    uart_address <= REG_RX_CLR;
                    uart_wd      <= '0;
                    uart_we      <= 1'b1;
                end
                RX_CLR0: begin
                    state        <= IDLE;
                    uart_address <= REG_RX_FLAG;
                end
                TX_LOAD: begin
                    state        <= TX_GO;
                    uart_address <= REG_TX_START;
                    uart_wd      <= WD_ONE;
                    uart_we      <= 1'b1;
                end
                TX_GO: begin
                    state        <= TX_REL;
                    uart_address <= REG_TX_START;
                    uart_wd      <= '0;
                    uart_we      <= 1'b1;
                end
                TX_REL: begin
                    state        <= TX_WLOW;
                    uart_address <= REG_TX_FINISH;
                    wait_cnt     <= '0;
                end
                TX_WLOW: begin
                    // A UART that finishes before we look never shows finish low; bail out after START_WAIT.
                    if (!uart_rd[0] || wait_cnt >= START_LIM) begin
                        state    <= TX_WHIGH;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
                    end
                end
                TX_WHIGH: begin
                    if (uart_rd[0]) begin
                        state        <= IDLE;
                        uart_address <= REG_RX_FLAG;
                    end else if (wait_cnt >= TIMEOUT_LIM) begin
                        tx_timeout   <= 1'b1;
                        state        <= IDLE;
                        uart_address <= REG_RX_FLAG;
                    end else begin
                        wait_cnt <= (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    uart_address <= REG_RX_FLAG;
                end
            endcase
            if (err_clr) tx_timeout <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_mmio_sequencer.sv
// Directed bench for uart_mmio_sequencer with a cycle-level UART register model and write log.
module tb_uart_mmio_sequencer;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    tx_byte;
    logic          tx_push;
    logic          tx_full;
    logic          tx_empty;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          busy;
    logic          tx_timeout;
    logic          err_clr;
    logic [DW-1:0] uart_address;
    logic [DW-1:0] uart_wd;
    logic          uart_we;
    logic [DW-1:0] uart_rd;

    always #5 clk = ~clk;

    uart_mmio_sequencer #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(8), .START_WAIT(16), .TX_TIMEOUT(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_byte(tx_byte), .tx_push(tx_push),
        .tx_full(tx_full), .tx_empty(tx_empty), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .busy(busy), .tx_timeout(tx_timeout), .err_clr(err_clr),
        .uart_address(uart_address), .uart_wd(uart_wd), .uart_we(uart_we), .uart_rd(uart_rd)
    );

    // UART register model: finish drops on start and rises finish_delay cycles later unless hung.
    logic       m_finish   = 1'b1;
    logic       m_rx_flag  = 1'b0;
    logic [7:0] m_rx_data  = 8'h00;
    int         m_count    = 0;
    int         finish_delay = 10;
    logic       hang       = 1'b0;
    logic       rx_inject  = 1'b0;
    logic [7:0] rx_inject_data = 8'h00;

    always_comb begin
        uart_rd = '0;
        case (uart_address)
            32'd3:   uart_rd = {31'b0, m_finish};
            32'd4:   uart_rd = {24'b0, m_rx_data};
            32'd5:   uart_rd = {31'b0, m_rx_flag};
            default: uart_rd = '0;
        endcase
    end

    always @(posedge clk) begin
        if (uart_we && uart_address == 32'd2 && uart_wd == 32'd1) begin
            m_finish <= 1'b0;
            m_count  <= finish_delay;
        end else if (!m_finish && !hang) begin
            if (m_count == 0) m_finish <= 1'b1;
            else              m_count  <= m_count - 1;
        end
        if (uart_we && uart_address == 32'd6 && uart_wd == 32'd1) m_rx_flag <= 1'b0;
        if (rx_inject) begin
            m_rx_flag <= 1'b1;
            m_rx_data <= rx_inject_data;
        end
    end

    logic [31:0] log_addr [$];
    logic [31:0] log_wd   [$];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_wd   [$];
    int          rx_count = 0;
    logic [7:0]  rx_last  = 8'h00;

    always @(negedge clk) begin
        if (uart_we) begin
            log_addr.push_back(uart_address);
            log_wd.push_back(uart_wd);
        end
        if (rx_valid) begin
            rx_count = rx_count + 1;
            rx_last  = rx_byte;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_wd.push_back(d);
    endtask

    task automatic exp_tx(input logic [7:0] b);
        exp_write(32'd1, {24'b0, b});
        exp_write(32'd2, 32'd1);
        exp_write(32'd2, 32'd0);
    endtask

    task automatic exp_rx();
        exp_write(32'd6, 32'd1);
        exp_write(32'd6, 32'd0);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 32'(log_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), log_addr[i], exp_addr[i]);
            check($sformatf("%s_wd%0d", tag, i), log_wd[i], exp_wd[i]);
        end
        log_addr.delete();
        log_wd.delete();
        exp_addr.delete();
        exp_wd.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_byte = b;
        tx_push = 1'b1;
        @(negedge clk);
        tx_push = 1'b0;
    endtask

    task automatic inject_rx(input logic [7:0] b);
        rx_inject_data = b;
        rx_inject = 1'b1;
        @(negedge clk);
        rx_inject = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!(!busy && tx_empty && !m_rx_flag) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reached_idle"}, 32'(!busy && tx_empty && !m_rx_flag), 32'd1);
    endtask

    task automatic wait_finish_poll(input string tag, input int budget);
        int n = 0;
        while (uart_address != 32'd3 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reached_poll"}, uart_address, 32'd3);
    endtask

    initial begin
        int n0;
        int lat;
        rst_n   = 1'b0;
        tx_byte = 8'h00;
        tx_push = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_empty",   32'(tx_empty),   32'd1);
        check("rst_full",    32'(tx_full),    32'd0);
        check("rst_busy",    32'(busy),       32'd0);
        check("rst_rxvalid", 32'(rx_valid),   32'd0);
        check("rst_rxbyte",  32'(rx_byte),    32'd0);
        check("rst_timeout", 32'(tx_timeout), 32'd0);
        check("rst_we",      32'(uart_we),    32'd0);
        check("rst_addr",    uart_address,    32'd5);
        check("rst_wd",      uart_wd,         32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte, finish rises 10 cycles after start
        push_byte(8'h41);
        wait_idle("t1", 200);
        exp_tx(8'h41);
        check_log("t1");
        check("t1_empty",   32'(tx_empty),   32'd1);
        check("t1_timeout", 32'(tx_timeout), 32'd0);

        // Fill the FIFO while a slow byte holds the FSM in the finish wait
        finish_delay = 40;
        push_byte(8'hEE);
        wait_finish_poll("t2", 20);
        finish_delay = 10;
        for (int i = 0; i < 8; i++) begin
            tx_byte = 8'(i);
            tx_push = 1'b1;
            @(negedge clk);
        end
        tx_push = 1'b0;
        check("t2_full_after_8", 32'(tx_full), 32'd1);
        tx_byte = 8'hFF;
        tx_push = 1'b1;
        @(negedge clk);
        tx_push = 1'b0;
        check("t2_full_after_drop", 32'(tx_full), 32'd1);
        wait_idle("t2", 1000);
        exp_tx(8'hEE);
        for (int i = 0; i < 8; i++) exp_tx(8'(i));
        check_log("t2");

        // RX while idle
        n0 = rx_count;
        inject_rx(8'h5A);
        wait_idle("t3", 100);
        check("t3_rx_pulses", 32'(rx_count - n0), 32'd1);
        check("t3_rx_last",   32'(rx_last),       32'h5A);
        check("t3_rx_byte",   32'(rx_byte),       32'h5A);
        check("t3_flag_low",  32'(m_rx_flag),     32'd0);
        exp_rx();
        check_log("t3");

        // RX arrives mid-TX with a second byte queued
        n0 = rx_count;
        push_byte(8'h10);
        push_byte(8'h11);
        wait_finish_poll("t4", 20);
        inject_rx(8'h33);
        wait_idle("t4", 300);
        check("t4_rx_pulses", 32'(rx_count - n0), 32'd1);
        check("t4_rx_last",   32'(rx_last),       32'h33);
        exp_tx(8'h10);
        exp_rx();
        exp_tx(8'h11);
        check_log("t4");

        // Finish never rises: timeout after ~50 cycles, then recovery and err_clr
        hang = 1'b1;
        push_byte(8'h77);
        wait_finish_poll("t5", 20);
        lat = 0;
        while (!tx_timeout && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("t5_timeout_set", 32'(tx_timeout), 32'd1);
        check("t5_latency_ok",  32'(lat >= 48 && lat <= 56), 32'd1);
        check("t5_back_idle",   32'(busy), 32'd0);
        hang = 1'b0;
        push_byte(8'h78);
        wait_idle("t5", 200);
        exp_tx(8'h77);
        exp_tx(8'h78);
        check_log("t5");
        check("t5_timeout_sticky", 32'(tx_timeout), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t5_err_clr", 32'(tx_timeout), 32'd0);

        // Asynchronous reset while waiting for finish with bytes still queued
        hang = 1'b1;
        push_byte(8'h90);
        push_byte(8'h91);
        push_byte(8'h92);
        wait_finish_poll("t6", 20);
        repeat (5) @(negedge clk);
        check("t6_pre_busy",  32'(busy),     32'd1);
        check("t6_pre_queue", 32'(tx_empty), 32'd0);
        exp_tx(8'h90);
        check_log("t6_pre");
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy",    32'(busy),       32'd0);
        check("t6_empty",   32'(tx_empty),   32'd1);
        check("t6_full",    32'(tx_full),    32'd0);
        check("t6_we",      32'(uart_we),    32'd0);
        check("t6_addr",    uart_address,    32'd5);
        check("t6_wd",      uart_wd,         32'd0);
        check("t6_rxvalid", 32'(rx_valid),   32'd0);
        check("t6_rxbyte",  32'(rx_byte),    32'd0);
        check("t6_timeout", 32'(tx_timeout), 32'd0);
        @(negedge clk);
        hang  = 1'b0;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_post_empty", 32'(tx_empty), 32'd1);
        check("t6_post_busy",  32'(busy),     32'd0);
        check_log("t6_post");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_mmio_sequencer.md
Name: uart_mmio_sequencer

Overview:
- Bus-master controller that drives the UART IP's memory-mapped register port (wd/address/we/rd) in place of the CPU.
- Buffers outgoing bytes in a small TX FIFO and sequences each byte through load, start, release and wait-for-finish.
- Polls the RX-received flag, captures each received byte, presents it to a consumer, then pulses the RX flag-clear register.
- Sits between the peripheral bus mux and uart_IP.

Parameters:
- DATA_WIDTH, 32, width of the UART register data and address bus.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, at least 2.
- START_WAIT, 16, maximum cycles to wait for tx-finish to drop after start.
- TX_TIMEOUT, 200000, maximum cycles to wait for tx-finish to rise; at least 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tx_byte  in  8  byte to enqueue
- tx_push  in  1  enqueue strobe; ignored when tx_full
- tx_full  out  1  FIFO holds FIFO_DEPTH entries
- tx_empty  out  1  FIFO holds 0 entries
- rx_byte  out  8  last received byte; held until the next capture
- rx_valid  out  1  1-cycle pulse when rx_byte updates
- busy  out  1  FSM not in IDLE
- tx_timeout  out  1  sticky error flag, set on TX_TIMEOUT expiry
- err_clr  in  1  clears tx_timeout
- uart_address  out  DATA_WIDTH  UART register word index (0..6)
- uart_wd  out  DATA_WIDTH  UART write data
- uart_we  out  1  UART write enable
- uart_rd  in  DATA_WIDTH  UART read data, combinational on uart_address

Behaviour:
- Register map (word index): 1 TX data, 2 TX start, 3 TX finish (read), 4 RX data (read), 5 RX received (read), 6 RX flag clear.
- Reset:
  - State IDLE; FIFO empty, so tx_empty=1 and tx_full=0.
  - rx_byte=0, rx_valid=0, busy=0, tx_timeout=0.
  - uart_we=0, uart_address=5, uart_wd=0; wait counter=0.
- A reset mid-transaction abandons it immediately. No writes are issued after rst_n deasserts until a new sequence begins.
- The FSM drives all uart_* outputs as registered values. uart_we is high for exactly one cycle per write state.
- States and transitions:
  - IDLE: uart_address=5.
    - If uart_rd[0]==1, go to RX_READ. RX has priority.
    - Else if the FIFO is not empty, go to TX_LOAD.
    - Else stay in IDLE.
  - RX_READ: address=4. Next cycle, capture uart_rd[7:0] into rx_byte and pulse rx_valid. Go to RX_CLR1.
  - RX_CLR1: write address 6, wd=1. Go to RX_CLR0.
  - RX_CLR0: write address 6, wd=0. Go to IDLE.
  - TX_LOAD: write address 1, wd = zero-extended FIFO head. Pop the FIFO in the same cycle. Go to TX_GO.
  - TX_GO: write address 2, wd=1. Go to TX_REL.
  - TX_REL: write address 2, wd=0. Clear the counter. Go to TX_WLOW.
  - TX_WLOW: address=3.
    - If uart_rd[0]==0, or the counter reaches START_WAIT, clear the counter and go to TX_WHIGH.
    - Else increment the counter.
  - TX_WHIGH: address=3.
    - If uart_rd[0]==1, go to IDLE.
    - Else if the counter reaches TX_TIMEOUT, set tx_timeout and go to IDLE.
    - Else increment the counter.
- A TX sequence is never preempted by RX; a pending RX is served at the next IDLE.
- The RX and TX flags are re-sampled in IDLE only. A byte received during TX is held by the UART flag until served.
- FIFO pointers:
  - Write and read pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
  - full = (MSBs differ, low bits equal); empty = (pointers equal).
  - Simultaneous push and pop when full: the pop proceeds and the push is dropped, since full is sampled before the pop.
  - Simultaneous push and pop when empty cannot occur, because a pop requires non-empty.
- err_clr takes priority over a same-cycle timeout set: tx_timeout ends the cycle at 0.
- Counter width is sized for max(START_WAIT, TX_TIMEOUT). The counter saturates and never wraps.

Test Plan:
- Reset, then push 0x41 with the UART model raising finish 10 cycles after start → writes seen in order: (1,0x41), (2,1), (2,0); FSM returns to IDLE; tx_empty=1; no tx_timeout.
- Push 8 bytes 0x00..0x07 back-to-back, then a 9th byte 0xFF → tx_full=1 after the 8th push; 0xFF dropped; the UART receives exactly 0x00..0x07 in order.
- Model asserts RX flag with RX data 0x5A while idle → rx_valid pulses once with rx_byte=0x5A; writes (6,1) then (6,0) follow; the flag is then low and IDLE resumes.
- RX flag raised mid-TX with 0x33 while 2 bytes are queued → the current byte completes, RX is served (rx_byte=0x33), then the remaining byte is sent.
- Finish never rises (TX_TIMEOUT=50) → tx_timeout=1 after about 50 cycles in TX_WHIGH; the next byte is still sent; err_clr returns tx_timeout to 0.
- Assert rst_n=0 during TX_WHIGH with 3 bytes queued → all outputs take reset values asynchronously; the FIFO is empty after release.
